// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter and its scoreboard.
package rv_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } gnt_e;

  function automatic logic reg_is_x0(input logic [REG_AW-1:0] r);
    return (r == REG_X0);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_chk.sv
// Simulation checks for the writeback arbiter: an ALU write must never target a
// register still owned by an outstanding long-latency op.
module regfile_wb_arbiter_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        a_grant,
  input logic [4:0]  a_reg,
  input logic [31:0] pending
);

  a_write_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !(a_grant && (a_reg != 5'd0) && pending[a_reg]));

endmodule

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for long-latency ops; a set and a clear of the
// same register in one cycle leaves the bit set because the new op owns it.
module wb_scoreboard
  import rv_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic [4:0]  set_reg,
  input  logic        clr_en,
  input  logic [4:0]  clr_reg,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic        rs1_hit,
  output logic        rs2_hit,
  output logic        rd_hit,
  output logic [31:0] pending
);

  logic [31:0] pending_r;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;

  // One-hot set/clear masks; x0 never enters the scoreboard
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (set_en && !reg_is_x0(set_reg)) begin
      set_mask_s[set_reg] = 1'b1;
    end else begin
      set_mask_s = 32'd0;
    end
    if (clr_en && !reg_is_x0(clr_reg)) begin
      clr_mask_s[clr_reg] = 1'b1;
    end else begin
      clr_mask_s = 32'd0;
    end
  end

  // Pending vector update, set applied after clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign rs1_hit = !reg_is_x0(rs1) && pending_r[rs1];
  assign rs2_hit = !reg_is_x0(rs2) && pending_r[rs2];
  assign rd_hit  = !reg_is_x0(rd)  && pending_r[rd];
  assign pending = pending_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (A) and the long-latency
// unit (B), and stalls issue on hazards against outstanding B destinations.
module regfile_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int XLEN     = rv_wb_pkg::XLEN,
  parameter int MAX_WAIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [4:0]      a_reg,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_reg,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  output logic            iss_stall,
  output logic            wr_ena,
  output logic [4:0]      wr_reg,
  output logic [XLEN-1:0] wr_data
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  gnt_e            gnt_s;
  logic [3:0]      wait_cnt_r;
  logic            wr_ena_r;
  logic [4:0]      wr_reg_r;
  logic [XLEN-1:0] wr_data_r;
  logic            rs1_hit_s, rs2_hit_s, rd_hit_s;
  logic            rs1_infl_s, rs2_infl_s;
  logic            sb_set_s, sb_clr_s;
  logic [31:0]     pending_s;

  // Grant: B wins contention until A has lost MAX_WAIT cycles in a row
  always_comb begin
    gnt_s = GNT_NONE;
    if (a_valid && b_valid) begin
      if (wait_cnt_r == MAX_WAIT_C) begin
        gnt_s = GNT_A;
      end else begin
        gnt_s = GNT_B;
      end
    end else if (a_valid) begin
      gnt_s = GNT_A;
    end else if (b_valid) begin
      gnt_s = GNT_B;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  assign a_ready = (gnt_s == GNT_A);
  assign b_ready = (gnt_s == GNT_B);

  // Consecutive-loss counter for A, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 4'd0;
    end else if (a_valid && !a_ready) begin
      if (wait_cnt_r != MAX_WAIT_C) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end else begin
      wait_cnt_r <= 4'd0;
    end
  end

  // Register the winning beat; an x0 beat is consumed but does not write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ena_r  <= 1'b0;
      wr_reg_r  <= 5'd0;
      wr_data_r <= '0;
    end else begin
      case (gnt_s)
        GNT_A: begin
          wr_ena_r  <= !reg_is_x0(a_reg);
          wr_reg_r  <= a_reg;
          wr_data_r <= a_data;
        end
        GNT_B: begin
          wr_ena_r  <= !reg_is_x0(b_reg);
          wr_reg_r  <= b_reg;
          wr_data_r <= b_data;
        end
        GNT_NONE: begin
          wr_ena_r <= 1'b0;
        end
        default: begin
          wr_ena_r <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ena  = wr_ena_r;
  assign wr_reg  = wr_reg_r;
  assign wr_data = wr_data_r;

  // A write sitting in the output register is not yet visible in the register file
  assign rs1_infl_s = wr_ena_r && (wr_reg_r == iss_rs1) && !reg_is_x0(iss_rs1);
  assign rs2_infl_s = wr_ena_r && (wr_reg_r == iss_rs2) && !reg_is_x0(iss_rs2);

  assign iss_stall = iss_valid &&
                     (rs1_hit_s || rs2_hit_s || rd_hit_s || rs1_infl_s || rs2_infl_s);

  assign sb_set_s = iss_valid && iss_long && !iss_stall && !reg_is_x0(iss_rd);
  assign sb_clr_s = b_ready && !reg_is_x0(b_reg);

  wb_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (sb_set_s),
    .set_reg (iss_rd),
    .clr_en  (sb_clr_s),
    .clr_reg (b_reg),
    .rs1     (iss_rs1),
    .rs2     (iss_rs2),
    .rd      (iss_rd),
    .rs1_hit (rs1_hit_s),
    .rs2_hit (rs2_hit_s),
    .rd_hit  (rd_hit_s),
    .pending (pending_s)
  );

  regfile_wb_arbiter_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_grant (a_ready),
    .a_reg   (a_reg),
    .pending (pending_s)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of grants, scoreboard and write port.
module tb_regfile_wb_arbiter;

  localparam int XW = 32;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, iss_valid, iss_long;
  logic [4:0]    a_reg, b_reg, iss_rd, iss_rs1, iss_rs2;
  logic [XW-1:0] a_data, b_data;
  logic          a_ready, b_ready, iss_stall, wr_ena;
  logic [4:0]    wr_reg;
  logic [XW-1:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  bit          pend[32];
  int          lost;
  bit          m_wr_ena;
  logic [4:0]  m_wr_reg;
  logic [31:0] m_wr_data;
  bit          m_ga, m_gb;

  regfile_wb_arbiter #(.XLEN(XW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
    .wr_ena(wr_ena), .wr_reg(wr_reg), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    lost      = 0;
    m_wr_ena  = 1'b0;
    m_wr_reg  = 5'd0;
    m_wr_data = 32'd0;
  endtask

  task automatic idle_in();
    a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
  endtask

  task automatic issue(input bit v, input bit lng, input int rd, input int rs1, input int rs2);
    iss_valid = v; iss_long = lng;
    iss_rd = 5'(rd); iss_rs1 = 5'(rs1); iss_rs2 = 5'(rs2);
  endtask

  function automatic bit hazard(input logic [4:0] r, input bit with_inflight);
    if (r == 5'd0) return 1'b0;
    return pend[r] || (with_inflight && m_wr_ena && (m_wr_reg == r));
  endfunction

  // One clock: check combinational outputs, advance the model, check write port.
  task automatic cycle();
    bit stall;
    #2;
    m_ga  = a_valid && (!b_valid || lost >= MW);
    m_gb  = b_valid && !m_ga;
    stall = iss_valid && (hazard(iss_rs1, 1'b1) || hazard(iss_rs2, 1'b1) || hazard(iss_rd, 1'b0));
    chk_val("a_ready", 32'(a_ready), 32'(m_ga));
    chk_val("b_ready", 32'(b_ready), 32'(m_gb));
    chk_val("iss_stall", 32'(iss_stall), 32'(stall));
    @(posedge clk);
    if (m_gb && b_reg != 5'd0) pend[b_reg] = 1'b0;
    if (iss_valid && iss_long && !stall && iss_rd != 5'd0) pend[iss_rd] = 1'b1;
    if (a_valid && !m_ga) lost = (lost + 1 > MW) ? MW : lost + 1;
    else lost = 0;
    if (m_ga) begin
      m_wr_ena = (a_reg != 5'd0); m_wr_reg = a_reg; m_wr_data = a_data;
    end else if (m_gb) begin
      m_wr_ena = (b_reg != 5'd0); m_wr_reg = b_reg; m_wr_data = b_data;
    end else begin
      m_wr_ena = 1'b0;
    end
    #1;
    chk_val("wr_ena", 32'(wr_ena), 32'(m_wr_ena));
    chk_val("wr_reg", 32'(wr_reg), 32'(m_wr_reg));
    chk_val("wr_data", wr_data, m_wr_data);
  endtask

  initial begin
    logic [4:0] plist[$];
    rst_n = 1'b0;
    idle_in();
    model_reset();
    #1;
    chk_val("rst_wr_ena", 32'(wr_ena), 32'd0);
    chk_val("rst_wr_reg", 32'(wr_reg), 32'd0);
    chk_val("rst_wr_data", wr_data, 32'd0);
    chk_val("rst_ready", 32'({a_ready, b_ready, iss_stall}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // A alone
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
    #1 chk_val("a_alone_ready", 32'(a_ready), 32'd1);
    cycle();
    chk_val("a_alone_ena", 32'(wr_ena), 32'd1);
    chk_val("a_alone_reg", 32'(wr_reg), 32'd5);
    chk_val("a_alone_data", wr_data, 32'hDEADBEEF);
    a_valid = 1'b0;
    cycle();
    chk_val("a_alone_ena_off", 32'(wr_ena), 32'd0);

    // contention: B, B, B, A, B
    a_valid = 1'b1; a_reg = 5'd20; b_valid = 1'b1; b_reg = 5'd21;
    for (int k = 0; k < 5; k++) begin
      a_data = $urandom; b_data = $urandom;
      #1 chk_val("contend_a_ready", 32'(a_ready), 32'(k == 3));
      cycle();
    end
    idle_in();
    cycle();

    // RAW on a long-latency destination
    issue(1'b1, 1'b1, 7, 1, 2);
    #1 chk_val("raw_first_issue", 32'(iss_stall), 32'd0);
    cycle();
    issue(1'b1, 1'b0, 8, 7, 0);
    #1 chk_val("raw_stall", 32'(iss_stall), 32'd1);
    cycle(); cycle();
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h0000_7777;
    cycle();
    b_valid = 1'b0;
    #1 chk_val("raw_inflight", 32'(iss_stall), 32'd1);
    cycle();
    #1 chk_val("raw_released", 32'(iss_stall), 32'd0);
    cycle();

    // WAW: reissue of rd=7 collides with its B writeback
    issue(1'b1, 1'b1, 7, 1, 2);
    cycle();
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h1234_5678;
    #1 chk_val("waw_stalled", 32'(iss_stall), 32'd1);
    cycle();
    b_valid = 1'b0;
    #1 chk_val("waw_represent", 32'(iss_stall), 32'd0);
    cycle();
    issue(1'b1, 1'b0, 0, 7, 0);
    #1 chk_val("waw_owned", 32'(iss_stall), 32'd1);
    cycle();
    issue(1'b0, 1'b0, 0, 0, 0);
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'hCAFE_0007;
    cycle();
    b_valid = 1'b0;
    cycle();

    // set and clear of the same register in one cycle: set wins
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h5E7_0007;
    issue(1'b1, 1'b1, 7, 1, 2);
    cycle();
    idle_in();
    cycle();
    issue(1'b1, 1'b0, 7, 0, 0);
    #1 chk_val("set_wins", 32'(iss_stall), 32'd1);
    cycle();
    idle_in();
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h0;
    cycle();
    idle_in();
    cycle();

    // x0 handling
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hBAD0_0000;
    #1 chk_val("x0_b_ready", 32'(b_ready), 32'd1);
    cycle();
    chk_val("x0_no_write", 32'(wr_ena), 32'd0);
    b_valid = 1'b0;
    issue(1'b1, 1'b1, 0, 0, 0);
    cycle();
    issue(1'b1, 1'b0, 0, 0, 0);
    #1 chk_val("x0_no_stall", 32'(iss_stall), 32'd0);
    cycle();
    idle_in();

    // async reset mid-cycle with wr_ena=1, pending[9]=1 and A waiting
    a_valid = 1'b1; a_reg = 5'd22; a_data = 32'hA0A0_A0A0;
    b_valid = 1'b1; b_reg = 5'd23; b_data = 32'hB0B0_B0B0;
    cycle(); cycle();
    issue(1'b1, 1'b1, 9, 1, 2);
    cycle();
    issue(1'b1, 1'b0, 0, 9, 0);
    #2 chk_val("pre_rst_stall", 32'(iss_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("mid_rst_wr_ena", 32'(wr_ena), 32'd0);
    chk_val("mid_rst_wr_data", wr_data, 32'd0);
    chk_val("mid_rst_pending", 32'(iss_stall), 32'd0);
    chk_val("mid_rst_wait_cnt", 32'({a_ready, b_ready}), 32'd1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1'b0, 1'b0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle();
    idle_in();
    cycle();

    // random traffic: A targets x0/x16..x31, long ops x0..x15, B drains pending
    for (int n = 0; n < 600; n++) begin
      if (!a_valid || m_ga) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
        a_data  = $urandom;
      end
      if (!b_valid || m_gb) begin
        plist.delete();
        for (int r = 1; r < 16; r++) if (pend[r]) plist.push_back(5'(r));
        b_data = $urandom;
        if (plist.size() > 0 && $urandom_range(0, 99) < 50) begin
          b_valid = 1'b1;
          b_reg   = plist[$urandom_range(0, plist.size() - 1)];
        end else begin
          b_valid = ($urandom_range(0, 19) == 0);
          b_reg   = 5'd0;
        end
      end
      iss_valid = ($urandom_range(0, 99) < 70);
      iss_long  = ($urandom_range(0, 99) < 40);
      iss_rd    = iss_long ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
      iss_rs1   = 5'($urandom_range(0, 31));
      iss_rs2   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
